// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of functional-unit results onto a registered common data bus
module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int TAG_W   = 4,
    parameter int PREG_W  = 7,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
    input  logic [NUM_SRC*PREG_W-1:0]   src_preg,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_wen,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [PREG_W-1:0]           cdb_preg,
    output logic [DATA_W-1:0]           cdb_data,
    output logic                        cdb_wen,
    output logic [$clog2(NUM_SRC)-1:0]  cdb_src,
    output logic [CNT_W-1:0]            conflict_cnt
);
    localparam int SW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] full, grant, wen_q;
    logic [TAG_W-1:0]   tag_q  [NUM_SRC];
    logic [PREG_W-1:0]  preg_q [NUM_SRC];
    logic [DATA_W-1:0]  data_q [NUM_SRC];
    logic [SW-1:0]      rr_ptr, gnt_idx, rr_nxt;
    logic               gnt_vld, win;

    function automatic logic [SW-1:0] wrap(input int v);
        return SW'(v % NUM_SRC);
    endfunction

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int j = NUM_SRC - 1; j >= 0; j--)
            if (full[wrap(int'(rr_ptr) + j)]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap(int'(rr_ptr) + j);
            end
    end

    assign win       = gnt_vld & ~flush;
    assign grant     = win ? NUM_SRC'(1) << gnt_idx : '0;
    assign src_ready = {NUM_SRC{rst & ~flush}} & (~full | grant);
    assign rr_nxt    = (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            full         <= '0;
            rr_ptr       <= '0;
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_preg     <= '0;
            cdb_data     <= '0;
            cdb_wen      <= 1'b0;
            cdb_src      <= '0;
            conflict_cnt <= '0;
        end else begin
            full      <= ~{NUM_SRC{flush}} & ((src_valid & src_ready) | (full & ~grant));
            cdb_valid <= win;
            cdb_wen   <= win & wen_q[gnt_idx];
            if (win) begin
                cdb_tag  <= tag_q[gnt_idx];
                cdb_preg <= preg_q[gnt_idx];
                cdb_data <= data_q[gnt_idx];
                cdb_src  <= gnt_idx;
                rr_ptr   <= rr_nxt;
            end
            if (!flush && $countones(full) >= 2 && !(&conflict_cnt))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++)
            if (src_valid[i] & src_ready[i]) begin
                tag_q[i]  <= src_tag[i*TAG_W +: TAG_W];
                preg_q[i] <= src_preg[i*PREG_W +: PREG_W];
                data_q[i] <= src_data[i*DATA_W +: DATA_W];
                wen_q[i]  <= src_wen[i];
            end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter, plus a narrow-counter instance for saturation
module tb_cdb_arbiter;
    localparam int N = 3, TW = 4, PW = 7, DW = 32;

    logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    src_valid, src_ready, src_ready2, src_wen;
    logic [N*TW-1:0] src_tag;
    logic [N*PW-1:0] src_preg;
    logic [N*DW-1:0] src_data;
    logic            cdb_valid, cdb_wen, cdb_valid2, cdb_wen2;
    logic [TW-1:0]   cdb_tag, cdb_tag2;
    logic [PW-1:0]   cdb_preg, cdb_preg2;
    logic [DW-1:0]   cdb_data, cdb_data2;
    logic [1:0]      cdb_src, cdb_src2;
    logic [15:0]     conflict_cnt;
    logic [1:0]      conflict_cnt2;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush), .src_valid(src_valid), .src_ready(src_ready),
        .src_tag(src_tag), .src_preg(src_preg), .src_data(src_data), .src_wen(src_wen),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
        .cdb_wen(cdb_wen), .cdb_src(cdb_src), .conflict_cnt(conflict_cnt)
    );

    cdb_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .src_valid(src_valid), .src_ready(src_ready2),
        .src_tag(src_tag), .src_preg(src_preg), .src_data(src_data), .src_wen(src_wen),
        .cdb_valid(cdb_valid2), .cdb_tag(cdb_tag2), .cdb_preg(cdb_preg2), .cdb_data(cdb_data2),
        .cdb_wen(cdb_wen2), .cdb_src(cdb_src2), .conflict_cnt(conflict_cnt2)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [PW-1:0] preg;
        logic [DW-1:0] data;
        logic          wen;
        logic [1:0]    src;
    } ent_t;

    ent_t exp_q[$];
    ent_t lst [N][8];
    ent_t me;
    int   cnt [N];
    int   ptr [N];
    int   n_chk = 0, n_bad = 0;
    logic [N-1:0] fire;

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", t, got, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            ptr[i] = 0;
        end
    endtask

    task automatic add(input int i, input logic [TW-1:0] tag, input logic [PW-1:0] preg,
                       input logic [DW-1:0] data, input logic wen);
        ent_t e;
        e.tag  = tag;
        e.preg = preg;
        e.data = data;
        e.wen  = wen;
        e.src  = 2'(i);
        lst[i][cnt[i]] = e;
        cnt[i]++;
    endtask

    task automatic expect_ent(input int i, input int k);
        exp_q.push_back(lst[i][k]);
    endtask

    task automatic tick();
        for (int i = 0; i < N; i++) begin
            src_valid[i] = ptr[i] < cnt[i];
            if (ptr[i] < cnt[i]) begin
                src_tag[i*TW +: TW]  = lst[i][ptr[i]].tag;
                src_preg[i*PW +: PW] = lst[i][ptr[i]].preg;
                src_data[i*DW +: DW] = lst[i][ptr[i]].data;
                src_wen[i]           = lst[i][ptr[i]].wen;
            end
        end
        #1 fire = src_valid & src_ready;
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (fire[i]) ptr[i]++;
        @(negedge clk);
    endtask

    always @(negedge clk)
        if (cdb_valid) begin
            if (exp_q.size() == 0)
                chk("extra_bcast", cdb_valid, 1'b0);
            else begin
                me = exp_q.pop_front();
                chk("cdb_tag", cdb_tag, me.tag);
                chk("cdb_preg", cdb_preg, me.preg);
                chk("cdb_data", cdb_data, me.data);
                chk("cdb_wen", cdb_wen, me.wen);
                chk("cdb_src", cdb_src, me.src);
            end
        end

    initial begin
        src_valid = '0;
        src_tag   = '0;
        src_preg  = '0;
        src_data  = '0;
        src_wen   = '0;
        clr();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++)
                add(i, TW'(i * 4 + k), PW'(i * 10 + k + 1), 32'hC0DE_0000 + i * 256 + k, 1'((i + k) % 2));
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++)
                expect_ent(i, k);
        @(negedge clk);
        repeat (3) begin
            tick();
            chk("rst_ready", src_ready, 3'b000);
            chk("rst_cdbv", cdb_valid, 1'b0);
            chk("rst_cnt", conflict_cnt, 16'd0);
        end
        rst = 1'b1;
        #1 chk("rel_ready", src_ready, 3'b111);
        repeat (3) tick();
        chk("rr_cnt_mid", conflict_cnt, 16'd2);
        chk("sat_mid", conflict_cnt2, 2'd2);
        repeat (9) tick();
        chk("rr_cnt_end", conflict_cnt, 16'd8);
        chk("sat_end", conflict_cnt2, 2'd3);
        chk("rr_drain", exp_q.size(), 0);

        clr();
        add(0, 4'd5, 7'd12, 32'hDEAD_BEEF, 1'b1);
        expect_ent(0, 0);
        tick();
        chk("lat_e1", cdb_valid, 1'b0);
        tick();
        chk("lat_e2", cdb_valid, 1'b1);
        chk("lat_wen", cdb_wen, 1'b1);
        tick();
        chk("lat_idle", cdb_valid, 1'b0);
        chk("lat_drain", exp_q.size(), 0);

        clr();
        add(0, 4'd1, 7'd21, 32'h1111_0001, 1'b1);
        add(0, 4'd2, 7'd22, 32'h1111_0002, 1'b0);
        add(1, 4'd3, 7'd23, 32'h2222_0003, 1'b0);
        add(2, 4'd4, 7'd24, 32'h3333_0004, 1'b1);
        expect_ent(1, 0);
        expect_ent(2, 0);
        expect_ent(0, 0);
        expect_ent(0, 1);
        tick();
        chk("bp_rdy1", src_ready[0], 1'b0);
        tick();
        chk("bp_rdy2", src_ready[0], 1'b0);
        tick();
        chk("bp_rdy3", src_ready[0], 1'b1);
        repeat (4) tick();
        chk("bp_drain", exp_q.size(), 0);

        clr();
        add(0, 4'd6, 7'd31, 32'h4444_0006, 1'b1);
        add(1, 4'd7, 7'd32, 32'h5555_0007, 1'b1);
        add(2, 4'd8, 7'd33, 32'h6666_0008, 1'b1);
        tick();
        chk("fl_pre_ready", src_ready, 3'b010);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_cdbv", cdb_valid, 1'b0);
        chk("fl_cnt", conflict_cnt, 16'd10);
        #1 chk("fl_empty", src_ready, 3'b111);
        clr();
        add(0, 4'd9, 7'd41, 32'h7777_0009, 1'b0);
        add(1, 4'd10, 7'd42, 32'h8888_000A, 1'b1);
        add(2, 4'd11, 7'd43, 32'h9999_000B, 1'b0);
        expect_ent(1, 0);
        expect_ent(2, 0);
        expect_ent(0, 0);
        repeat (5) tick();
        chk("fl_rr_drain", exp_q.size(), 0);
        clr();
        add(0, 4'd12, 7'd50, 32'hCAFE_F00D, 1'b1);
        expect_ent(0, 0);
        tick();
        chk("fl_lat_e1", cdb_valid, 1'b0);
        tick();
        chk("fl_lat_e2", cdb_valid, 1'b1);
        tick();
        chk("fl_lat_drain", exp_q.size(), 0);
        chk("final_cnt", conflict_cnt, 16'd12);
        chk("final_sat", conflict_cnt2, 2'd3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) between the out-of-order core's functional units (ALU, branch, LSU). Each unit hands its completed result over a valid/ready handshake into a private one-entry holding slot. The arbiter grants one slot per cycle and drives a registered CDB broadcast consumed by the ROB, the reservation stations and the PRF write port. Sits between the execute stage outputs and the writeback/commit logic in the top-level core.

## Interface
Parameters:
- NUM_SRC, 3: number of requesting functional units; index 0=ALU, 1=branch, 2=LSU
- TAG_W, 4: ROB tag width
- PREG_W, 7: physical register index width
- DATA_W, 32: result data width
- CNT_W, 16: conflict counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- flush  in  1  mispredict flush; discards all pending and in-flight results
- src_valid  in  NUM_SRC  per-unit result valid
- src_ready  out  NUM_SRC  per-unit slot can accept this cycle
- src_tag  in  NUM_SRC×TAG_W  packed ROB tags, unit i at [i*TAG_W +: TAG_W]
- src_preg  in  NUM_SRC×PREG_W  packed destination physical registers
- src_data  in  NUM_SRC×DATA_W  packed result values
- src_wen  in  NUM_SRC  per-unit result writes a register (0 for stores/branches without rd)
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast ROB tag
- cdb_preg  out  PREG_W  broadcast physical register
- cdb_data  out  DATA_W  broadcast value
- cdb_wen  out  1  PRF write enable for broadcast (cdb_valid & winning wen)
- cdb_src  out  $clog2(NUM_SRC)  index of unit that produced the broadcast
- conflict_cnt  out  CNT_W  saturating count of cycles with ≥2 full slots

## Operation
- Per unit: one holding slot {full, tag, preg, data, wen}.
- src_ready[i] = !flush & (!full[i] | grant[i]). Same-cycle refill of a granted slot is allowed.
- Handshake fires when src_valid[i] & src_ready[i]. Slot i loads at that edge. A unit holding valid with ready low keeps its payload stable.
- Arbitration is combinational over full[]. The search starts at rr_ptr and scans upward modulo NUM_SRC. The first full slot wins. At most one grant per cycle.
- On grant to i: the CDB output registers load slot i at the next edge, full[i] clears unless refilled, and rr_ptr ← (i+1) mod NUM_SRC.
- With no grant, cdb_valid is 0 next cycle and rr_ptr holds.
- Flush: at the edge where flush=1, every full[] clears, the grant is suppressed, cdb_valid is 0 next cycle and rr_ptr holds. A broadcast already registered (visible during the flush cycle) is not retracted.
- conflict_cnt increments each cycle with popcount(full) ≥ 2 and flush=0. It saturates at 2^CNT_W−1 and clears only on reset.
- Reset (rst=0 at edge) has priority over flush and clears:
  - full[] = 0
  - rr_ptr = 0
  - cdb_valid = 0, cdb_tag/preg/data = 0, cdb_wen = 0, cdb_src = 0
  - conflict_cnt = 0
- src_ready is 0 while rst=0.

## Timing
- Latency: a handshake at edge E makes the slot full after E. With no contention, the grant is in that cycle and cdb_valid is high in the cycle after edge E+1, i.e. 2 edges from handshake to broadcast.
- Throughput: 1 broadcast per cycle aggregate. A lone unit sustains 1 result/cycle via same-cycle refill.
- Fairness: with all NUM_SRC slots continuously full, each unit is granted exactly once every NUM_SRC cycles. Worst-case wait is NUM_SRC−1 cycles.
- cdb_* outputs are registered only; there are no combinational paths from src_* to cdb_*.
- src_ready depends combinationally on flush and the registered full[]/rr_ptr only, never on src_valid.

## Test plan
- Reset: hold rst=0 three cycles with src_valid=3'b111 → src_ready=0, cdb_valid=0, conflict_cnt=0. After release, src_ready=3'b111.
- Single-source latency: ALU alone sends tag=5, preg=12, data=0xDEADBEEF, wen=1 at edge E → cdb_valid=1 with those values, cdb_src=0, cdb_wen=1, in the cycle after E+1.
- Round robin: all three units send back-to-back continuously from reset → cdb_src sequence 0,1,2,0,1,2… and conflict_cnt increments every cycle while ≥2 slots are full.
- Back-pressure: ALU, branch and LSU all valid with one result pending each, plus ALU offering a second result → ALU src_ready=0 until its slot is granted. The ALU's second tag appears on the CDB only after the branch and LSU broadcasts, and no result is lost or duplicated.
- Flush: three slots full, assert flush one cycle → next cycle cdb_valid=0, all slots empty, rr_ptr unchanged. A new ALU result after flush broadcasts with normal 2-edge latency.
- Saturation: set CNT_W=2 and hold ≥2 slots full for 6 cycles → conflict_cnt reads 3 and stays 3.
